// File: rtl/crt_pkg.sv
// CRT controller register-file package: CR index map, CR07 protection mask,
// packed-image geometry and the index-to-slot lookup shared by the RTL.
package crt_pkg;

  // CR index map (VGA CRT controller)
  localparam logic [7:0] CR_HTOTAL  = 8'h00;
  localparam logic [7:0] CR_HDEND   = 8'h01;
  localparam logic [7:0] CR_HBSTART = 8'h02;
  localparam logic [7:0] CR_HBEND   = 8'h03;
  localparam logic [7:0] CR_HSSTART = 8'h04;
  localparam logic [7:0] CR_HSEND   = 8'h05;
  localparam logic [7:0] CR_VTOTAL  = 8'h06;
  localparam logic [7:0] CR_OVFL    = 8'h07;
  localparam logic [7:0] CR_PRESET  = 8'h08;
  localparam logic [7:0] CR_MAXSCAN = 8'h09;
  localparam logic [7:0] CR_CSTART  = 8'h0A;
  localparam logic [7:0] CR_CEND    = 8'h0B;
  localparam logic [7:0] CR_VSSTART = 8'h10;
  localparam logic [7:0] CR_VSEND   = 8'h11;
  localparam logic [7:0] CR_VDEND   = 8'h12;
  localparam logic [7:0] CR_OFFSET  = 8'h13;
  localparam logic [7:0] CR_ULOC    = 8'h14;
  localparam logic [7:0] CR_VBSTART = 8'h15;
  localparam logic [7:0] CR_VBEND   = 8'h16;
  localparam logic [7:0] CR_MODE    = 8'h17;
  localparam logic [7:0] CR_LCMP    = 8'h18;

  // Packed image geometry: 20 byte slots
  localparam int CRT_REGS_W = 160;
  localparam int NUM_SLOTS  = CRT_REGS_W / 8;
  localparam int SLOT_W     = 5;

  // Slots with special handling
  localparam logic [SLOT_W-1:0] SLOT_CR06 = 5'd6;
  localparam logic [SLOT_W-1:0] SLOT_CR07 = 5'd7;
  localparam logic [SLOT_W-1:0] SLOT_CR11 = 5'd13;

  // Bits of CR07 held while CR11[7] write protection is active (bit 4 stays writable)
  localparam logic [7:0] CR07_PROT_MASK = 8'hEF;

  typedef struct packed {
    logic              hit;   // index is a mapped data register
    logic [SLOT_W-1:0] slot;  // byte slot in the packed image
  } cr_slot_t;

  // Map a CR index onto its packed-image byte slot; CR13 and 0C-0F/19+ are unmapped.
  function automatic cr_slot_t cr_slot(input logic [7:0] index);
    cr_slot_t s;
    s.hit  = 1'b1;
    s.slot = '0;
    if (index <= CR_CEND) begin
      s.slot = index[SLOT_W-1:0];
    end else if (index >= CR_VSSTART && index <= CR_VDEND) begin
      s.slot = index[SLOT_W-1:0] - 5'd4;
    end else if (index >= CR_ULOC && index <= CR_LCMP) begin
      s.slot = index[SLOT_W-1:0] - 5'd5;
    end else begin
      s.hit = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/crt_vint.sv
// Vertical-retrace interrupt: vsync rising-edge detector plus pending flag.
// Instantiated only when CRT_VINT_EN is defined.
module crt_vint (
  input  logic h_hclk,
  input  logic h_reset,
  input  logic vsync_i,      // vertical sync, synchronous to h_hclk
  input  logic vint_en_i,    // registered CR11[4]: 0 holds pending clear
  input  logic vint_mask_i,  // registered CR11[5]: masks the request only
  input  logic vint_clr_i,   // CR11 write with bit 4 = 0 this cycle
  output logic vint_pend_o,
  output logic c_vint_o
);

  logic vsync_q;
  logic pend_q, pend_d;

  // Pending next state: clear dominates a coincident vsync edge
  always_comb begin
    // NOTE: default first so every path assigns pend_d and no latch is inferred.
    pend_d = pend_q;
    if (vint_clr_i || !vint_en_i) begin
      pend_d = 1'b0;
    end else if (vsync_i && !vsync_q) begin
      pend_d = 1'b1;
    end
  end

  // vsync history and pending flag
  always_ff @(posedge h_hclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (h_reset) begin
      vsync_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      pend_q  <= pend_d;
    end
  end

  assign vint_pend_o = pend_q;
  assign c_vint_o    = pend_q & ~vint_mask_i;

endmodule

// File: rtl/crt_reg_file.sv
// CRT controller data-register file: CR00-CR0B and CR10-CR18 (no CR13),
// CR11[7] write protection, registered high-lane read data, packed image
// for the timing generators.
// Optional feature macro: CRT_VINT_EN enables the vertical-retrace interrupt;
// without it vint_pend/c_vint are tied low while CR11[5:4] remain storable.
module crt_reg_file
  import crt_pkg::*;
(
  input  logic                  h_hclk,
  input  logic                  h_reset,
  input  logic [7:0]            crtc_index,
  input  logic                  trim_wr,
  input  logic                  crt_data_hit,
  input  logic                  crt_mod_rd_en_hb,
  input  logic [15:0]           h_io_dbus,
  input  logic                  vsync,
  output logic [7:0]            crt_rd_data,
  output logic [CRT_REGS_W-1:0] crt_regs,
  output logic                  vint_pend,
  output logic                  c_vint
);

  logic [7:0] regs_q [NUM_SLOTS];
  logic [7:0] regs_d [NUM_SLOTS];
  logic [7:0] rd_data_q, rd_data_d;

  cr_slot_t   sel;
  logic [7:0] wdata;
  logic       wr_en;
  logic [7:0] cr11_q;
  logic       protect;

  assign sel     = cr_slot(crtc_index);
  assign wdata   = h_io_dbus[15:8];
  assign wr_en   = trim_wr & crt_data_hit;
  assign cr11_q  = regs_q[SLOT_CR11];
  assign protect = cr11_q[7];

  // Register write path with CR11[7] protection of CR00-CR07
  always_comb begin
    regs_d = regs_q;
    if (wr_en && sel.hit) begin
      if (protect && sel.slot == SLOT_CR07) begin
        regs_d[SLOT_CR07] = (regs_q[SLOT_CR07] & CR07_PROT_MASK) |
                            (wdata & ~CR07_PROT_MASK);
      end else if (!(protect && sel.slot <= SLOT_CR06)) begin
        regs_d[sel.slot] = wdata;
      end
    end
  end

  // Read data: loads on a high-lane read from pre-write contents, holds otherwise
  always_comb begin
    rd_data_d = rd_data_q;
    if (crt_mod_rd_en_hb) begin
      rd_data_d = sel.hit ? regs_q[sel.slot] : 8'h00;
    end
  end

  // Register file and read-data state
  always_ff @(posedge h_hclk) begin
    if (h_reset) begin
      // NOTE: the whole file is reset because the timing generators consume
      // every byte directly; this is flops, not an inferred RAM.
      for (int i = 0; i < NUM_SLOTS; i++) regs_q[i] <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) regs_q[i] <= regs_d[i];
      rd_data_q <= rd_data_d;
    end
  end

  assign crt_rd_data = rd_data_q;

  // Packed image: byte k is slot k
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_image
    assign crt_regs[g*8 +: 8] = regs_q[g];
  end

`ifdef CRT_VINT_EN
  logic cr11_clr;
  logic unused_lo_lane;

  assign cr11_clr       = wr_en & (crtc_index == CR_VSEND) & ~wdata[4];
  assign unused_lo_lane = ^h_io_dbus[7:0];

  crt_vint u_vint (
    .h_hclk      (h_hclk),
    .h_reset     (h_reset),
    .vsync_i     (vsync),
    .vint_en_i   (cr11_q[4]),
    .vint_mask_i (cr11_q[5]),
    .vint_clr_i  (cr11_clr),
    .vint_pend_o (vint_pend),
    .c_vint_o    (c_vint)
  );
`else
  logic unused_vint_inputs;

  assign unused_vint_inputs = ^{h_io_dbus[7:0], vsync};
  assign vint_pend          = 1'b0;
  assign c_vint             = 1'b0;
`endif

endmodule
